// File: rtl/ioc_bus_pkg.sv
// Shared definitions for the IOC register bus sequencer: opcode layout, FSM states
// and error flag bit positions.
package ioc_bus_pkg;

    localparam int unsigned RW_BIT  = 7;
    localparam int unsigned MOD_MSB = 6;
    localparam int unsigned MOD_LSB = 5;
    localparam int unsigned IOC_MSB = 4;

    localparam int unsigned ERR_ILLEGAL_MOD = 0;
    localparam int unsigned ERR_ABORT       = 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StLoad,
        StFetch,
        StWaitRd,
        StDrain
    } state_e;

endpackage

// File: rtl/ioc_bus_sequencer_if.sv
// SPI byte side and IOC register bus side of the sequencer, bundled as one interface.
// The master modport is the sequencer; the slave modport is its environment.
interface ioc_bus_sequencer_if #(
    parameter int unsigned NUM_MODULES = 4
);
    logic                     i_frame_cs;
    logic [7:0]               i_rx_byte;
    logic                     i_rx_valid;
    logic [7:0]               o_tx_byte;
    logic                     o_tx_valid;
    logic [4:0]               o_ioc;
    logic [7:0]               o_data;
    logic [NUM_MODULES-1:0]   o_cs;
    logic                     o_fetch_cmd;
    logic                     o_load_cmd;
    logic [8*NUM_MODULES-1:0] i_data_in;
    logic                     i_err_clr;
    logic [1:0]               o_err_flags;
    logic                     o_busy;

    modport master (
        input  i_frame_cs, i_rx_byte, i_rx_valid, i_data_in, i_err_clr,
        output o_tx_byte, o_tx_valid, o_ioc, o_data, o_cs, o_fetch_cmd, o_load_cmd,
               o_err_flags, o_busy
    );

    modport slave (
        output i_frame_cs, i_rx_byte, i_rx_valid, i_data_in, i_err_clr,
        input  o_tx_byte, o_tx_valid, o_ioc, o_data, o_cs, o_fetch_cmd, o_load_cmd,
               o_err_flags, o_busy
    );
endinterface

// File: rtl/ioc_bus_sequencer_rdata_mux.sv
// Selects one module's 8-bit read data slice from the packed bus; out-of-range
// selects return zero.
module ioc_rdata_mux #(
    parameter int unsigned NUM_MODULES = 4
) (
    input  logic [8*NUM_MODULES-1:0] data_in_i,
    input  logic [1:0]               sel_i,
    output logic [7:0]               rdata_o
);

    always_comb begin
        rdata_o = '0;
        for (int unsigned m = 0; m < NUM_MODULES; m++) begin
            if (sel_i == 2'(m)) begin
                rdata_o = data_in_i[8*m +: 8];
            end
        end
    end

endmodule

// File: rtl/ioc_bus_sequencer.sv
// Decodes SPI opcode/data bytes into single-cycle IOC register reads and writes,
// and returns read data to the SPI transmitter. All outputs are registered.
module ioc_bus_sequencer
    import ioc_bus_pkg::*;
#(
    parameter int unsigned NUM_MODULES = 4,
    parameter int unsigned FETCH_LAT   = 1
) (
    input  logic                i_sys_clk,
    input  logic                i_rst_b,
    ioc_bus_sequencer_if.master bus
);

    state_e                 state_q, state_d;
    logic [1:0]             mod_q, mod_d;
    logic [4:0]             op_ioc_q, op_ioc_d;
    logic [2:0]             lat_cnt_q, lat_cnt_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [4:0]             ioc_q, ioc_d;
    logic [7:0]             data_q, data_d;
    logic [NUM_MODULES-1:0] cs_q, cs_d;
    logic                   fetch_q, fetch_d;
    logic                   load_q, load_d;
    logic [1:0]             err_q, err_d;
    logic                   busy_q, busy_d;

    logic                   rx_ok;
    logic [1:0]             rx_mod;
    logic [7:0]             rdata;

    function automatic logic [NUM_MODULES-1:0] mod_onehot(input logic [1:0] m);
        logic [NUM_MODULES-1:0] oh;
        oh    = '0;
        oh[0] = 1'b1;
        return oh << m;
    endfunction

    assign rx_ok  = bus.i_frame_cs & bus.i_rx_valid;
    assign rx_mod = bus.i_rx_byte[MOD_MSB:MOD_LSB];

    ioc_rdata_mux #(
        .NUM_MODULES (NUM_MODULES)
    ) u_rdata_mux (
        .data_in_i (bus.i_data_in),
        .sel_i     (mod_q),
        .rdata_o   (rdata)
    );

    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        op_ioc_d   = op_ioc_q;
        lat_cnt_d  = lat_cnt_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        ioc_d      = ioc_q;
        data_d     = data_q;
        cs_d       = '0;
        fetch_d    = 1'b0;
        load_d     = 1'b0;
        // Clear first so that a new error raised this cycle still sticks.
        err_d      = bus.i_err_clr ? 2'b00 : err_q;

        unique case (state_q)
            StIdle: begin
                if (rx_ok) begin
                    mod_d    = rx_mod;
                    op_ioc_d = bus.i_rx_byte[IOC_MSB:0];
                    if (32'(rx_mod) >= NUM_MODULES) begin
                        err_d[ERR_ILLEGAL_MOD] = 1'b1;
                        state_d                = StDrain;
                    end else if (bus.i_rx_byte[RW_BIT]) begin
                        state_d = StWaitData;
                    end else begin
                        fetch_d = 1'b1;
                        cs_d    = mod_onehot(rx_mod);
                        ioc_d   = bus.i_rx_byte[IOC_MSB:0];
                        state_d = StFetch;
                    end
                end
            end
            StWaitData: begin
                if (!bus.i_frame_cs) begin
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = StIdle;
                end else if (bus.i_rx_valid) begin
                    data_d  = bus.i_rx_byte;
                    load_d  = 1'b1;
                    cs_d    = mod_onehot(mod_q);
                    ioc_d   = op_ioc_q;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StDrain;
            end
            StFetch: begin
                lat_cnt_d = '0;
                state_d   = StWaitRd;
            end
            StWaitRd: begin
                // Abort takes priority over a read completing in the same cycle.
                if (!bus.i_frame_cs) begin
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = StIdle;
                end else if (lat_cnt_q == 3'(FETCH_LAT - 1)) begin
                    tx_byte_d  = rdata;
                    tx_valid_d = 1'b1;
                    state_d    = StDrain;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StDrain: begin
                if (!bus.i_frame_cs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q    <= StIdle;
            mod_q      <= '0;
            op_ioc_q   <= '0;
            lat_cnt_q  <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            ioc_q      <= '0;
            data_q     <= '0;
            cs_q       <= '0;
            fetch_q    <= 1'b0;
            load_q     <= 1'b0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            op_ioc_q   <= op_ioc_d;
            lat_cnt_q  <= lat_cnt_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ioc_q      <= ioc_d;
            data_q     <= data_d;
            cs_q       <= cs_d;
            fetch_q    <= fetch_d;
            load_q     <= load_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_byte   = tx_byte_q;
    assign bus.o_tx_valid  = tx_valid_q;
    assign bus.o_ioc       = ioc_q;
    assign bus.o_data      = data_q;
    assign bus.o_cs        = cs_q;
    assign bus.o_fetch_cmd = fetch_q;
    assign bus.o_load_cmd  = load_q;
    assign bus.o_err_flags = err_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_ioc_bus_sequencer.sv
// Directed bench for ioc_bus_sequencer (3 modules, FETCH_LAT=1); bus strobes and
// read responses are checked against a queue of expected events with cycle stamps.
module tb_ioc_bus_sequencer;

    localparam int unsigned NM = 3;
    localparam int unsigned FL = 1;

    localparam int KLoad  = 0;
    localparam int KFetch = 1;
    localparam int KTx    = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] cs;
        logic [4:0] ioc;
        logic [7:0] b;
    } exp_t;

    logic clk;
    logic rst_b;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    ioc_bus_sequencer_if #(.NUM_MODULES(NM)) bus ();

    ioc_bus_sequencer #(
        .NUM_MODULES (NM),
        .FETCH_LAT   (FL)
    ) u_dut (
        .i_sys_clk (clk),
        .i_rst_b   (rst_b),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_byte  = b;
        bus.i_rx_valid = 1'b1;
        step();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic push(input int kind, input int at, input logic [2:0] cs,
                        input logic [4:0] ioc, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.cs   = cs;
        e.ioc  = ioc;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic match(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == KTx) begin
                chk("tx_byte", 32'(bus.o_tx_byte), 32'(e.b));
            end else begin
                chk("strobe_cs", 32'(bus.o_cs), 32'(e.cs));
                chk("strobe_ioc", 32'(bus.o_ioc), 32'(e.ioc));
                if (kind == KLoad) chk("strobe_data", 32'(bus.o_data), 32'(e.b));
            end
        end
    endtask

    // Scoreboard monitor: sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rst_b) begin
            if (bus.o_fetch_cmd && bus.o_load_cmd) chk("fetch_and_load", 32'd1, 32'd0);
            if (bus.o_load_cmd) match(KLoad);
            if (bus.o_fetch_cmd) match(KFetch);
            if (bus.o_tx_valid) match(KTx);
        end
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        rst_b    = 1'b0;
        bus.i_frame_cs = 1'b0;
        bus.i_rx_byte  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_err_clr  = 1'b0;
        bus.i_data_in  = {8'h99, 8'h37, 8'hA5};
        step();
        step();
        chk("reset_outputs", {bus.o_tx_byte, bus.o_ioc, bus.o_data, bus.o_tx_valid},
            32'h0);
        chk("reset_strobes", {bus.o_cs, bus.o_fetch_cmd, bus.o_load_cmd, bus.o_err_flags,
            bus.o_busy}, 32'h0);
        rst_b = 1'b1;
        step();
        step();

        // Write to module 0, ioc 0x04, then trailing bytes that must be ignored.
        bus.i_frame_cs = 1'b1;
        step();
        send(8'h84);
        chk("wr_busy", 32'(bus.o_busy), 32'd1);
        chk("wr_no_early_load", 32'(bus.o_load_cmd), 32'd0);
        push(KLoad, cyc + 1, 3'b001, 5'h04, 8'h5A);
        send(8'h5A);
        chk("wr_load", {bus.o_load_cmd, bus.o_cs, bus.o_ioc, bus.o_data}, {1'b1, 3'b001,
            5'h04, 8'h5A});
        step();
        chk("wr_load_one_cycle", {bus.o_load_cmd, bus.o_cs}, 4'b0000);
        chk("wr_hold", {bus.o_ioc, bus.o_data}, {5'h04, 8'h5A});
        send(8'hC4);
        send(8'h11);
        step();
        chk("drain_busy", 32'(bus.o_busy), 32'd1);
        bus.i_frame_cs = 1'b0;
        step();
        chk("drain_idle", 32'(bus.o_busy), 32'd0);
        step();

        // Read module 1 ioc 0x01, then module 2 ioc 0x0A.
        bus.i_frame_cs = 1'b1;
        step();
        push(KFetch, cyc + 1, 3'b010, 5'h01, 8'h00);
        push(KTx, cyc + 2 + FL, 3'b000, 5'h00, 8'h37);
        send(8'h21);
        chk("rd_fetch", {bus.o_fetch_cmd, bus.o_load_cmd, bus.o_cs, bus.o_ioc},
            {1'b1, 1'b0, 3'b010, 5'h01});
        step();
        chk("rd_fetch_one_cycle", {bus.o_fetch_cmd, bus.o_cs}, 4'b0000);
        step();
        chk("rd_tx", {bus.o_tx_valid, bus.o_tx_byte}, {1'b1, 8'h37});
        step();
        chk("rd_tx_hold", {bus.o_tx_valid, bus.o_tx_byte}, {1'b0, 8'h37});
        bus.i_frame_cs = 1'b0;
        step();
        bus.i_frame_cs = 1'b1;
        step();
        push(KFetch, cyc + 1, 3'b100, 5'h0A, 8'h00);
        push(KTx, cyc + 2 + FL, 3'b000, 5'h00, 8'h99);
        send(8'h4A);
        step();
        step();
        step();
        chk("rd2_tx_byte", 32'(bus.o_tx_byte), 32'h99);
        bus.i_frame_cs = 1'b0;
        step();

        // Illegal module index 3 with only 3 modules.
        bus.i_frame_cs = 1'b1;
        step();
        send(8'h60);
        step();
        step();
        step();
        chk("illegal_err", 32'(bus.o_err_flags), 32'h1);
        chk("illegal_busy", 32'(bus.o_busy), 32'd1);
        bus.i_frame_cs = 1'b0;
        step();
        chk("illegal_idle", 32'(bus.o_busy), 32'd0);
        bus.i_err_clr = 1'b1;
        step();
        bus.i_err_clr = 1'b0;
        chk("err_clear", 32'(bus.o_err_flags), 32'h0);

        // Abort before the data byte, then abort together with a clear.
        bus.i_frame_cs = 1'b1;
        step();
        send(8'h85);
        bus.i_frame_cs = 1'b0;
        step();
        chk("abort_wr_err", {bus.o_err_flags, bus.o_busy}, {2'b10, 1'b0});
        bus.i_frame_cs = 1'b1;
        step();
        send(8'h85);
        bus.i_frame_cs = 1'b0;
        bus.i_err_clr  = 1'b1;
        step();
        bus.i_err_clr  = 1'b0;
        chk("abort_set_wins", 32'(bus.o_err_flags), 32'h2);
        bus.i_err_clr = 1'b1;
        step();
        bus.i_err_clr = 1'b0;
        chk("abort_cleared", 32'(bus.o_err_flags), 32'h0);

        // Abort while waiting for read data: fetch happens, no response.
        bus.i_frame_cs = 1'b1;
        step();
        push(KFetch, cyc + 1, 3'b010, 5'h02, 8'h00);
        send(8'h22);
        bus.i_frame_cs = 1'b0;
        step();
        step();
        chk("abort_rd_err", {bus.o_err_flags, bus.o_busy, bus.o_tx_valid},
            {2'b10, 1'b0, 1'b0});
        bus.i_err_clr = 1'b1;
        step();
        bus.i_err_clr = 1'b0;

        // Asynchronous reset while waiting for read data.
        bus.i_frame_cs = 1'b1;
        step();
        push(KFetch, cyc + 1, 3'b010, 5'h01, 8'h00);
        send(8'h21);
        step();
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_outputs", {bus.o_tx_byte, bus.o_ioc, bus.o_data, bus.o_tx_valid},
            32'h0);
        chk("rst_mid_ctrl", {bus.o_cs, bus.o_fetch_cmd, bus.o_load_cmd, bus.o_err_flags,
            bus.o_busy}, 32'h0);
        step();
        rst_b = 1'b1;
        bus.i_frame_cs = 1'b0;
        step();
        step();
        step();
        chk("rst_no_tx", 32'(bus.o_tx_valid), 32'd0);
        bus.i_frame_cs = 1'b1;
        step();
        push(KFetch, cyc + 1, 3'b010, 5'h01, 8'h00);
        push(KTx, cyc + 2 + FL, 3'b000, 5'h00, 8'h37);
        send(8'h21);
        step();
        step();
        chk("rst_next_rd", {bus.o_tx_valid, bus.o_tx_byte}, {1'b1, 8'h37});
        bus.i_frame_cs = 1'b0;
        step();
        step();
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
